// File: rtl/text_console_ctrl.sv
// Text console controller: turns a character stream into character-plane writes,
// handling cursor motion, line wrap with line clearing, and full-screen clear.
module text_console_ctrl #(
  parameter int ROW_NUMBER     = 16,
  parameter int COL_NUMBER     = 32,
  parameter int CHAR_ID_LENGTH = 8,
  parameter int ROW_BIT_LEN    = 4,
  parameter int COL_BIT_LEN    = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHAR_ID_LENGTH-1:0] in_char,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      clear_req,
  output logic                      wr_en,
  output logic [ROW_BIT_LEN-1:0]    wr_row,
  output logic [COL_BIT_LEN-1:0]    wr_col,
  output logic [CHAR_ID_LENGTH-1:0] wr_char,
  output logic [ROW_BIT_LEN-1:0]    cursor_row,
  output logic [COL_BIT_LEN-1:0]    cursor_col,
  output logic                      busy
);

  localparam logic [ROW_BIT_LEN-1:0]    ROW_LAST = ROW_BIT_LEN'(ROW_NUMBER - 1);
  localparam logic [COL_BIT_LEN-1:0]    COL_LAST = COL_BIT_LEN'(COL_NUMBER - 1);
  localparam logic [CHAR_ID_LENGTH-1:0] BLANK    = CHAR_ID_LENGTH'(8'h20);
  localparam logic [CHAR_ID_LENGTH-1:0] CH_BS    = CHAR_ID_LENGTH'(8'h08);
  localparam logic [CHAR_ID_LENGTH-1:0] CH_LF    = CHAR_ID_LENGTH'(8'h0A);
  localparam logic [CHAR_ID_LENGTH-1:0] CH_FF    = CHAR_ID_LENGTH'(8'h0C);
  localparam logic [CHAR_ID_LENGTH-1:0] CH_CR    = CHAR_ID_LENGTH'(8'h0D);

  typedef enum logic [1:0] {IDLE, WRITE, LINE_CLEAR, CLEAR} state_t;

  state_t                    state, state_nxt;
  logic                      wr_en_nxt;
  logic [ROW_BIT_LEN-1:0]    wr_row_nxt, cursor_row_nxt, pend_row, pend_row_nxt;
  logic [COL_BIT_LEN-1:0]    wr_col_nxt, cursor_col_nxt, pend_col, pend_col_nxt;
  logic [CHAR_ID_LENGTH-1:0] wr_char_nxt;
  logic                      pend_lc, pend_lc_nxt;
  logic                      clear_pend, clear_pend_nxt;
  logic                      ready_q;
  logic                      go_clear;
  logic                      accept;
  logic [ROW_BIT_LEN-1:0]    row_inc;

  assign in_ready = ready_q && !clear_req;
  assign accept   = in_valid && in_ready;
  assign row_inc  = (cursor_row == ROW_LAST) ? '0 : cursor_row + ROW_BIT_LEN'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wr_en      <= 1'b0;
      wr_row     <= '0;
      wr_col     <= '0;
      wr_char    <= '0;
      cursor_row <= '0;
      cursor_col <= '0;
      pend_row   <= '0;
      pend_col   <= '0;
      pend_lc    <= 1'b0;
      clear_pend <= 1'b0;
      ready_q    <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      wr_en      <= wr_en_nxt;
      wr_row     <= wr_row_nxt;
      wr_col     <= wr_col_nxt;
      wr_char    <= wr_char_nxt;
      cursor_row <= cursor_row_nxt;
      cursor_col <= cursor_col_nxt;
      pend_row   <= pend_row_nxt;
      pend_col   <= pend_col_nxt;
      pend_lc    <= pend_lc_nxt;
      clear_pend <= clear_pend_nxt;
      ready_q    <= (state_nxt == IDLE) && !clear_pend_nxt;
      busy       <= (state_nxt != IDLE);
    end
  end

  always_comb begin
    state_nxt      = state;
    wr_en_nxt      = 1'b0;
    wr_row_nxt     = wr_row;
    wr_col_nxt     = wr_col;
    wr_char_nxt    = wr_char;
    cursor_row_nxt = cursor_row;
    cursor_col_nxt = cursor_col;
    pend_row_nxt   = pend_row;
    pend_col_nxt   = pend_col;
    pend_lc_nxt    = pend_lc;
    go_clear       = 1'b0;
    // A clear request seen mid-operation is remembered; one seen during CLEAR is absorbed.
    clear_pend_nxt = clear_pend || (clear_req && state != IDLE && state != CLEAR);

    case (state)
      IDLE: begin
        if (clear_req || clear_pend) begin
          go_clear = 1'b1;
        end else if (accept) begin
          if (in_char >= BLANK) begin
            state_nxt   = WRITE;
            wr_en_nxt   = 1'b1;
            wr_row_nxt  = cursor_row;
            wr_col_nxt  = cursor_col;
            wr_char_nxt = in_char;
            if (cursor_col == COL_LAST) begin
              pend_row_nxt = row_inc;
              pend_col_nxt = '0;
              pend_lc_nxt  = 1'b1;
            end else begin
              pend_row_nxt = cursor_row;
              pend_col_nxt = cursor_col + COL_BIT_LEN'(1);
              pend_lc_nxt  = 1'b0;
            end
          end else begin
            case (in_char)
              CH_LF: begin
                state_nxt    = LINE_CLEAR;
                wr_en_nxt    = 1'b1;
                wr_row_nxt   = row_inc;
                wr_col_nxt   = '0;
                wr_char_nxt  = BLANK;
                pend_row_nxt = row_inc;
                pend_col_nxt = '0;
              end
              CH_CR: cursor_col_nxt = '0;
              CH_BS: begin
                if (cursor_col != '0) begin
                  state_nxt    = WRITE;
                  wr_en_nxt    = 1'b1;
                  wr_row_nxt   = cursor_row;
                  wr_col_nxt   = cursor_col - COL_BIT_LEN'(1);
                  wr_char_nxt  = BLANK;
                  pend_row_nxt = cursor_row;
                  pend_col_nxt = cursor_col - COL_BIT_LEN'(1);
                  pend_lc_nxt  = 1'b0;
                end
              end
              CH_FF:   go_clear = 1'b1;
              default: ;
            endcase
          end
        end
      end

      WRITE: begin
        cursor_row_nxt = pend_row;
        cursor_col_nxt = pend_col;
        if (pend_lc) begin
          state_nxt   = LINE_CLEAR;
          wr_en_nxt   = 1'b1;
          wr_row_nxt  = pend_row;
          wr_col_nxt  = '0;
          wr_char_nxt = BLANK;
        end else if (clear_pend_nxt) begin
          go_clear = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end

      LINE_CLEAR: begin
        if (wr_col == COL_LAST) begin
          cursor_row_nxt = pend_row;
          cursor_col_nxt = pend_col;
          if (clear_pend_nxt) go_clear = 1'b1;
          else                state_nxt = IDLE;
        end else begin
          wr_en_nxt  = 1'b1;
          wr_col_nxt = wr_col + COL_BIT_LEN'(1);
        end
      end

      CLEAR: begin
        if (wr_row == ROW_LAST && wr_col == COL_LAST) begin
          state_nxt      = IDLE;
          cursor_row_nxt = '0;
          cursor_col_nxt = '0;
        end else begin
          wr_en_nxt = 1'b1;
          if (wr_col == COL_LAST) begin
            wr_col_nxt = '0;
            wr_row_nxt = wr_row + ROW_BIT_LEN'(1);
          end else begin
            wr_col_nxt = wr_col + COL_BIT_LEN'(1);
          end
        end
      end

      default: state_nxt = IDLE;
    endcase

    if (go_clear) begin
      state_nxt      = CLEAR;
      wr_en_nxt      = 1'b1;
      wr_row_nxt     = '0;
      wr_col_nxt     = '0;
      wr_char_nxt    = BLANK;
      clear_pend_nxt = 1'b0;
    end
  end

endmodule

// File: tb/tb_text_console_ctrl.sv
// Bench for text_console_ctrl: a screen-level model predicts every plane write
// and the final cursor; a negedge monitor pops expected writes as wr_en appears.
module tb_text_console_ctrl;
  localparam int ROWS = 16;
  localparam int COLS = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_char = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       clear_req = 1'b0;
  logic       wr_en;
  logic [3:0] wr_row;
  logic [4:0] wr_col;
  logic [7:0] wr_char;
  logic [3:0] cursor_row;
  logic [4:0] cursor_col;
  logic       busy;

  text_console_ctrl dut (
    .clk(clk), .reset(reset), .in_char(in_char), .in_valid(in_valid),
    .in_ready(in_ready), .clear_req(clear_req), .wr_en(wr_en), .wr_row(wr_row),
    .wr_col(wr_col), .wr_char(wr_char), .cursor_row(cursor_row),
    .cursor_col(cursor_col), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int exp_q[$];
  int wr_seen = 0;
  int m_row = 0;
  int m_col = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int enc(input int r, input int c, input int ch);
    return (r << 16) | (c << 8) | ch;
  endfunction

  task automatic push_row(input int r);
    for (int c = 0; c < COLS; c++) exp_q.push_back(enc(r, c, 32));
  endtask

  task automatic push_all();
    for (int r = 0; r < ROWS; r++) push_row(r);
    m_row = 0;
    m_col = 0;
  endtask

  // Screen-level reference: writes expected for one accepted character
  task automatic model_accept(input int ch, output int nw);
    int n0;
    n0 = exp_q.size();
    if (ch >= 32) begin
      exp_q.push_back(enc(m_row, m_col, ch));
      if (m_col == COLS - 1) begin
        m_row = (m_row + 1) % ROWS;
        m_col = 0;
        push_row(m_row);
      end else begin
        m_col++;
      end
    end else if (ch == 10) begin
      m_row = (m_row + 1) % ROWS;
      m_col = 0;
      push_row(m_row);
    end else if (ch == 13) begin
      m_col = 0;
    end else if (ch == 8) begin
      if (m_col > 0) begin
        m_col--;
        exp_q.push_back(enc(m_row, m_col, 32));
      end
    end else if (ch == 12) begin
      push_all();
    end
    nw = exp_q.size() - n0;
  endtask

  always @(negedge clk) begin
    if (!reset && wr_en) begin
      wr_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", enc(int'(wr_row), int'(wr_col), int'(wr_char)), -1);
      end else begin
        check("write", enc(int'(wr_row), int'(wr_col), int'(wr_char)), exp_q.pop_front());
      end
    end
  end

  // Call at a negedge; returns just after the accepting posedge
  task automatic xfer(input int ch, output int nw);
    logic [7:0] cb;
    bit rdy;
    rdy = 1'b0;
    cb = 8'(ch);
    in_valid = 1'b1;
    in_char = cb;
    for (int n = 0; n < 2000; n++) begin
      #1 rdy = in_ready;
      @(posedge clk);
      if (rdy) break;
      @(negedge clk);
    end
    #1 in_valid = 1'b0;
    if (!rdy) begin
      check("accept_timeout", 0, 1);
      nw = 0;
    end else begin
      model_accept(ch, nw);
    end
  endtask

  task automatic wait_idle(input string name, input int exp_busy, input int pulse_at);
    int cnt;
    bit done;
    cnt = 0;
    done = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      clear_req = (cnt == pulse_at);
      if (busy) cnt++;
      else begin
        done = 1'b1;
        break;
      end
    end
    clear_req = 1'b0;
    if (!done) check({name, "_idle_timeout"}, 0, 1);
    check({name, "_busy_cycles"}, cnt, exp_busy);
    check({name, "_cursor_row"}, int'(cursor_row), m_row);
    check({name, "_cursor_col"}, int'(cursor_col), m_col);
    check({name, "_writes_left"}, exp_q.size(), 0);
    #1 check({name, "_in_ready"}, int'(in_ready), 1);
    @(negedge clk);
  endtask

  initial begin
    int nw;
    int p;
    int ch;

    #1;
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_wr_pos", enc(int'(wr_row), int'(wr_col), int'(wr_char)), 0);
    check("rst_cursor", enc(int'(cursor_row), int'(cursor_col), 0), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1 check("rst_release_ready", int'(in_ready), 1);
    @(negedge clk);

    xfer(8'h41, nw);
    wait_idle("char_A", nw, -1);

    // Walk to (3,31), then print at the last column to force wrap + line clear
    for (int i = 0; i < 3; i++) begin xfer(10, nw); wait_idle("lf_walk", nw, -1); end
    for (int i = 0; i < 31; i++) begin xfer(8'h61 + (i % 26), nw); wait_idle("fill", nw, -1); end
    check("at_3_31", enc(int'(cursor_row), int'(cursor_col), 0), enc(3, 31, 0));
    xfer(8'h42, nw);
    check("wrap_nw", nw, 33);
    wait_idle("wrap", nw, -1);

    // Row 15 LF wraps to row 0; BS at col 0 does nothing
    for (int i = 0; i < 11; i++) begin xfer(10, nw); wait_idle("lf_walk2", nw, -1); end
    for (int i = 0; i < 5; i++) begin xfer(8'h30 + i, nw); wait_idle("fill2", nw, -1); end
    xfer(10, nw);
    wait_idle("lf_wrap", nw, -1);
    xfer(8, nw);
    wait_idle("bs_col0", nw, -1);

    // Clear and char in the same cycle; clear_req held well into CLEAR
    clear_req = 1'b1;
    in_valid = 1'b1;
    in_char = 8'h55;
    #1 check("clear_blocks_ready", int'(in_ready), 0);
    push_all();
    repeat (200) @(negedge clk);
    clear_req = 1'b0;
    xfer(8'h55, nw);
    wait_idle("after_clear", nw, -1);

    // clear_req pulse during LINE_CLEAR chains into CLEAR without an idle gap
    xfer(10, nw);
    push_all();
    wait_idle("lc_then_clear", nw + ROWS * COLS, 5);

    // Reset in the middle of a CLEAR sweep
    xfer(8'h5A, nw);
    wait_idle("pre_abort", nw, -1);
    wr_seen = 0;
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    push_all();
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      #2;
      if (wr_seen >= 100) break;
    end
    check("abort_cell", wr_seen, 100);
    reset = 1'b1;
    #1;
    check("abort_wr_en", int'(wr_en), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_cursor", enc(int'(cursor_row), int'(cursor_col), 0), 0);
    exp_q.delete();
    m_row = 0;
    m_col = 0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_release_ready", int'(in_ready), 1);
    check("abort_release_busy", int'(busy), 0);
    @(negedge clk);

    for (int i = 0; i < 250; i++) begin
      p = $urandom_range(0, 99);
      if (p < 70)      ch = $urandom_range(32, 255);
      else if (p < 78) ch = 10;
      else if (p < 84) ch = 13;
      else if (p < 92) ch = 8;
      else if (p < 94) ch = 12;
      else begin
        ch = $urandom_range(0, 31);
        if (ch == 8 || ch == 10 || ch == 12 || ch == 13) ch = 1;
      end
      xfer(ch, nw);
      wait_idle("rand", nw, -1);
    end

    repeat (4) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/text_console_ctrl.md
TEXT_CONSOLE_CTRL -- requirements
Module: text_console_ctrl

Interface
REQ-001 Parameter ROW_NUMBER, 16, text rows in character plane.
REQ-002 Parameter COL_NUMBER, 32, characters per row.
REQ-003 Parameter CHAR_ID_LENGTH, 8, character id width.
REQ-004 Parameter ROW_BIT_LEN, 4, row index width.
REQ-005 Parameter COL_BIT_LEN, 5, column index width.
REQ-006 One clock; reset is asynchronous and active-high.
REQ-007 clk  input  1  system clock; all state updates on rising edge.
REQ-008 reset  input  1  asynchronous active-high reset.
REQ-009 in_char  input  CHAR_ID_LENGTH  incoming character code.
REQ-010 in_valid  input  1  in_char valid.
REQ-011 in_ready  output  1  controller accepts in_char this cycle.
REQ-012 clear_req  input  1  request full-screen clear (level, sampled).
REQ-013 wr_en  output  1  character-plane write strobe.
REQ-014 wr_row  output  ROW_BIT_LEN  write row.
REQ-015 wr_col  output  COL_BIT_LEN  write column.
REQ-016 wr_char  output  CHAR_ID_LENGTH  write data.
REQ-017 cursor_row  output  ROW_BIT_LEN  current cursor row.
REQ-018 cursor_col  output  COL_BIT_LEN  current cursor column.
REQ-019 busy  output  1  high whenever state is not IDLE.

Function
REQ-020 FSM states SHALL be IDLE, WRITE, LINE_CLEAR, CLEAR; all outputs registered.
REQ-021 in_ready SHALL be 1 only in IDLE with clear_pend=0 and clear_req=0; transfer occurs on edge where in_valid && in_ready.
REQ-022 Printable code (0x20-0xFF) accepted: next cycle in WRITE, wr_en=1, wr_row/wr_col=cursor, wr_char=in_char; one-cycle pulse; then IDLE.
REQ-023 After printable write, cursor_col SHALL increment; at col COL_NUMBER-1, col->0, row->row+1 (ROW_NUMBER-1 wraps to 0) and FSM SHALL enter LINE_CLEAR instead of IDLE.
REQ-024 LINE_CLEAR SHALL write 0x20 to every column of cursor_row, col 0..COL_NUMBER-1 ascending, one write per cycle (COL_NUMBER cycles, wr_en=1 each), then IDLE.
REQ-025 0x0A (LF): cursor_col->0, row->row+1 with wrap, then LINE_CLEAR of new row.
REQ-026 0x0D (CR): cursor_col->0, no write, remain IDLE.
REQ-027 0x08 (BS): if cursor_col>0, col->col-1 and WRITE 0x20 at new position; if col=0, no change, no write.
REQ-028 0x0C (FF) SHALL behave as clear_req.
REQ-029 Other codes 0x00-0x1F SHALL be consumed with no write and no cursor change.
REQ-030 CLEAR SHALL write 0x20 to all ROW_NUMBER*COL_NUMBER cells, row-major from (0,0), one per cycle (512 cycles default), then set cursor (0,0) and return to IDLE.
REQ-031 clear_req in IDLE SHALL start CLEAR next cycle and take priority over simultaneous in_valid (char not accepted).
REQ-032 clear_req asserted outside IDLE SHALL set clear_pend; CLEAR SHALL start immediately after current operation ends; clear_pend cleared on CLEAR entry.
REQ-033 clear_req held high during CLEAR SHALL NOT restart or re-queue CLEAR.
REQ-034 wr_en SHALL be 0 in IDLE; wr_row/wr_col/wr_char hold last value when wr_en=0.
REQ-035 Cursor outputs SHALL change only at operation end, never mid LINE_CLEAR/CLEAR.

Reset
REQ-036 reset=1 SHALL immediately force IDLE, wr_en=0, wr_row=0, wr_col=0, wr_char=0, cursor (0,0), clear_pend=0, busy=0.
REQ-037 Reset mid-CLEAR/LINE_CLEAR SHALL abort the sweep; screen contents not restored; in_ready=1 first cycle after release.

Verification
REQ-038 Reset, send 'A'(0x41) -> one wr_en pulse row0 col0 char 0x41; cursor (0,1); in_ready low 1 cycle.
REQ-039 From (3,31) send 0x42 -> write (3,31)=0x42, then 32 writes of 0x20 on row 4, cursor (4,0), busy 33 cycles.
REQ-040 Cursor (15,5), send 0x0A -> LINE_CLEAR row 0, cursor (0,0); send 0x08 at col 0 -> no write.
REQ-041 clear_req and in_valid same IDLE cycle -> char not accepted, 512 writes of 0x20 (0,0)..(15,31), cursor (0,0), then char accepted.
REQ-042 clear_req pulse during LINE_CLEAR -> LINE_CLEAR completes all 32 writes, CLEAR follows with no IDLE cycle.
REQ-043 Reset asserted at CLEAR cell 100 -> wr_en=0 same cycle, cursor (0,0), IDLE after release.
